// File: rtl/mem_req_demux.sv
// mem_req_demux
//   Routes one memory request at a time from a single initiator to one of two
//   targets. Address nibble [31:28] == MMIO_REGION selects target 1 (MMIO), any
//   other value selects target 0 (RAM). The request fields are registered once
//   and shared by both targets. The selected target's response, or a timeout
//   error, is returned to the initiator as a one-cycle pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      initiator request handshake (ready only in IDLE)
//   req_addr/wdata/we/be     initiator request fields
//   rsp_valid/rdata/err      one-cycle response pulse; rdata/err are 0 otherwise
//   t_addr/wdata/we/be       registered request fields shared by both targets
//   t0_valid/t1_valid        per-target request valid
//   t0_ready/t1_ready        per-target request accept
//   t0_rsp_valid/t1_rsp_valid, t0_rdata/t1_rdata   per-target response
module mem_req_demux #(
  parameter logic [3:0]  MMIO_REGION = 4'h8,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] t_addr,
  output logic [31:0] t_wdata,
  output logic        t_we,
  output logic [3:0]  t_be,
  output logic        t0_valid,
  output logic        t1_valid,
  input  logic        t0_ready,
  input  logic        t1_ready,
  input  logic        t0_rsp_valid,
  input  logic        t1_rsp_valid,
  input  logic [31:0] t0_rdata,
  input  logic [31:0] t1_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        sel;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        sel_ready, sel_rsp;
  logic [31:0] sel_rdata;
  logic        timeout_hit;
  logic        capture, time_out;

  // Only the selected target's handshake signals are ever looked at.
  assign sel_ready   = sel ? t1_ready     : t0_ready;
  assign sel_rsp     = sel ? t1_rsp_valid : t0_rsp_valid;
  assign sel_rdata   = sel ? t1_rdata     : t0_rdata;
  assign timeout_hit = (cnt == TIMEOUT_CNT);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    time_out  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        // A response qualifies only together with the accept; it also beats
        // a timeout landing in the same cycle.
        if (sel_ready && sel_rsp) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          time_out  = 1'b1;
          state_nxt = RESP;
        end else if (sel_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (sel_rsp) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          time_out  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t_addr  <= '0;
      t_wdata <= '0;
      t_we    <= 1'b0;
      t_be    <= '0;
      sel     <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        t_addr  <= req_addr;
        t_wdata <= req_wdata;
        t_we    <= req_we;
        t_be    <= req_be;
        sel     <= (req_addr[31:28] == MMIO_REGION);
        cnt     <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (capture) begin
        rdata_q <= sel_rdata;
        err_q   <= 1'b0;
      end else if (time_out) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign t0_valid  = (state == ISSUE) && !sel;
  assign t1_valid  = (state == ISSUE) &&  sel;
  assign rsp_valid = (state == RESP);
  // Gate the held response so the initiator sees zeros outside the pulse.
  assign rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_req_demux.sv
// tb_mem_req_demux
//   Randomized and directed transactions against a transaction-level model:
//   for a request whose ready arrives at ISSUE-relative cycle r and whose
//   response pulse arrives at cycle s, the response is normal iff r <= s <= T
//   and is presented one cycle after s, otherwise a timeout error is presented
//   at cycle T+1. The request phase lasts through cycle min(r, T).
module tb_mem_req_demux;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_we;
  logic [3:0]  t_be;
  logic        t0_valid, t1_valid;
  logic        t0_ready, t1_ready;
  logic        t0_rsp_valid, t1_rsp_valid;
  logic [31:0] t0_rdata, t1_rdata;

  int n_chk = 0;
  int n_fail = 0;

  mem_req_demux #(.MMIO_REGION(4'h8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .t_addr(t_addr), .t_wdata(t_wdata), .t_we(t_we), .t_be(t_be),
    .t0_valid(t0_valid), .t1_valid(t1_valid),
    .t0_ready(t0_ready), .t1_ready(t1_ready),
    .t0_rsp_valid(t0_rsp_valid), .t1_rsp_valid(t1_rsp_valid),
    .t0_rdata(t0_rdata), .t1_rdata(t1_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_targets();
    t0_ready = 1'b0; t1_ready = 1'b0;
    t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0;
    t0_rdata = '0; t1_rdata = '0;
  endtask

  // Drive both targets for one cycle: selected side follows the plan, the
  // other side produces random noise that must never matter.
  task automatic drive_targets(input logic sl, input logic rdy, input logic rv,
                               input logic [31:0] rd, input logic noise_rv);
    if (sl) begin
      t1_ready = rdy; t1_rsp_valid = rv; t1_rdata = rd;
      t0_ready = 1'($urandom % 2); t0_rsp_valid = noise_rv; t0_rdata = $urandom;
    end else begin
      t0_ready = rdy; t0_rsp_valid = rv; t0_rdata = rd;
      t1_ready = 1'($urandom % 2); t1_rsp_valid = noise_rv; t1_rdata = $urandom;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_tvalid"}, {t0_valid, t1_valid}, 0);
  endtask

  // Entered and left in an IDLE cycle (between edges).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] be,
                         input int r, input int s, input logic [31:0] rd,
                         input bit noise_all, input bit hold);
    logic sl;
    bit   ok;
    int   done, iss_end;
    logic [31:0] exp_data;
    sl       = (addr[31:28] == 4'h8);
    ok       = (s >= r) && (s <= TMO);
    done     = ok ? s : TMO;
    iss_end  = (r < TMO) ? r : TMO;
    exp_data = ok ? rd : 32'h0;

    check("accept_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we; req_be = be;
    // Responses while idle must be ignored.
    drive_targets(sl, 1'($urandom % 2), 1'($urandom % 2), $urandom, 1'($urandom % 2));
    tick();
    if (!hold) req_valid = 1'b0;

    for (int k = 0; k <= done; k++) begin
      check("t_sel_valid", sl ? t1_valid : t0_valid, 32'(k <= iss_end));
      check("t_oth_valid", sl ? t0_valid : t1_valid, 0);
      check("busy_ready", req_ready, 0);
      check("busy_rsp", {rsp_valid, rsp_err}, 0);
      check("busy_rdata", rsp_rdata, 0);
      check("t_addr", t_addr, addr);
      check("t_wdata", t_wdata, wdata);
      check("t_we_be", {t_we, t_be}, {we, be});
      drive_targets(sl, 1'(k >= r), 1'(k == s), (k == s) ? rd : $urandom,
                    noise_all ? 1'b1 : 1'($urandom % 2));
      tick();
    end

    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_data);
    check("rsp_err", rsp_err, 32'(!ok));
    check("rsp_tvalid", {t0_valid, t1_valid}, 0);
    check("rsp_ready", req_ready, 0);
    // A late selected response during the response cycle must be ignored.
    drive_targets(sl, 1'b1, 1'b1, $urandom, 1'b1);
    tick();
    clear_targets();
    check_idle_outputs("post");
  endtask

  initial begin
    logic [31:0] a;
    int r, s;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_be = '0;
    clear_targets();
    tick(); tick();
    check_idle_outputs("reset");
    check("reset_t_fields", t_addr | t_wdata | {27'd0, t_we, t_be}, 0);
    rst = 1'b0;
    tick();

    // Load to RAM, accept and respond together.
    run_txn(32'h0000_0100, 32'hA5A5_0000, 1'b0, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0);
    // Store to MMIO with three cycles of backpressure.
    run_txn(32'h8000_0004, 32'h1234_5678, 1'b1, 4'b0011, 3, 5, 32'h0BAD_F00D, 0, 0);
    // No response: timeout error.
    run_txn(32'h0000_0200, 32'h0, 1'b0, 4'hF, 0, 255, 32'h1111_1111, 0, 0);
    // Other target hammering its response line.
    run_txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, 0, 4, 32'h0000_0005, 1, 0);
    // Boundaries: response on the timeout cycle wins; one later loses.
    run_txn(32'h8000_0010, 32'h0, 1'b0, 4'hF, 2, TMO, 32'hCAFE_0001, 0, 0);
    run_txn(32'h8000_0014, 32'h0, 1'b0, 4'hF, 2, TMO + 1, 32'hCAFE_0002, 0, 0);
    run_txn(32'h0000_0018, 32'h0, 1'b0, 4'hF, TMO, TMO, 32'hCAFE_0003, 0, 0);
    run_txn(32'h0000_001C, 32'h0, 1'b0, 4'hF, TMO + 2, TMO + 2, 32'hCAFE_0004, 0, 0);
    // Response before the accept is not a response.
    run_txn(32'h0000_0020, 32'h0, 1'b0, 4'hF, 3, 1, 32'hCAFE_0005, 0, 0);

    // Reset in WAIT followed by a late response.
    req_valid = 1'b1; req_addr = 32'h0000_0400; req_wdata = 32'h7777_7777; req_we = 1'b1; req_be = 4'hC;
    tick();
    req_valid = 1'b0;
    t0_ready = 1'b1;
    tick();
    t0_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_wait");
    check("rst_wait_t_fields", t_addr | t_wdata | {27'd0, t_we, t_be}, 0);
    t0_rsp_valid = 1'b1; t0_rdata = 32'h9999_9999;
    tick();
    clear_targets();
    check_idle_outputs("rst_late1");
    tick();
    check_idle_outputs("rst_late2");
    run_txn(32'h0000_0500, 32'h0, 1'b0, 4'hF, 1, 2, 32'h0000_ABCD, 0, 0);

    // Back-to-back with req_valid held high.
    run_txn(32'h8000_0600, 32'h1, 1'b1, 4'h1, 0, 1, 32'h0000_0601, 0, 1);
    run_txn(32'h0000_0700, 32'h2, 1'b0, 4'h3, 1, 1, 32'h0000_0701, 0, 1);
    run_txn(32'h8000_0800, 32'h3, 1'b0, 4'h7, 0, 0, 32'h0000_0801, 0, 0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom % 2) a[31:28] = 4'h8;
      r = ($urandom % 8 == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 5));
      case ($urandom % 4)
        0:       s = 255;
        1:       s = int'($urandom_range(0, 18));
        default: s = r + int'($urandom_range(0, 6));
      endcase
      run_txn(a, $urandom, 1'($urandom % 2), 4'($urandom), r, s, $urandom,
              1'($urandom % 2), 1'($urandom % 2));
      if (!req_valid)
        for (int j = 0; j < int'($urandom % 3); j++) begin
          tick();
          check_idle_outputs("gap");
        end
    end
    req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
